// File: rtl/cdc_hs_tx.sv
// cdc_hs_tx: source-domain end of a 4-phase req/ack CDC word transfer.
// Optional ack-wait timeout is built when CDC_HS_TX_TIMEOUT_EN is defined.
module cdc_hs_tx #(
   parameter int DATA_WIDTH     = 16,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  src_valid,
   output logic                  src_ready,
   input  logic [DATA_WIDTH-1:0] src_data,
   output logic                  src_done,
   output logic                  busy,
   output logic                  tx_req,
   output logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_ack_async,
   output logic                  timeout_err
);

   typedef enum logic [1:0] {IDLE, REQ, ACK_LOW} state_t;

   state_t                  state_q, state_d;
   logic [SYNC_STAGES-1:0]  ack_sync_q;
   logic                    ack_s;
   logic                    tx_req_q, tx_req_d;
   logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
   logic                    src_done_q, src_done_d;
   logic                    to_hit;

   // Returning ack is asynchronous; only the last flop of this chain is used.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ack_sync_q <= '0;
      end else begin
         ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], tx_ack_async};
      end
   end

   assign ack_s = ack_sync_q[SYNC_STAGES-1];

`ifdef CDC_HS_TX_TIMEOUT_EN
   localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_err_q, timeout_err_d;

   assign to_hit = (cnt_q == CNT_LAST);

   always_comb begin
      cnt_d         = cnt_q;
      timeout_err_d = 1'b0;
      if (state_q == IDLE && src_valid) begin
         cnt_d = '0;
      end else if (state_q == REQ) begin
         cnt_d = cnt_q + 1'b1;
         if (!ack_s && to_hit) begin
            timeout_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q         <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign timeout_err = timeout_err_q;
`else
   assign to_hit      = 1'b0;
   // Constant 0 in this build; a negative limit is not a legal configuration.
   assign timeout_err = (TIMEOUT_CYCLES < 0) ? 1'b1 : 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      tx_req_d   = tx_req_q;
      tx_data_d  = tx_data_q;
      src_done_d = 1'b0;
      src_ready  = 1'b0;
      unique case (state_q)
         IDLE: begin
            src_ready = 1'b1;
            if (src_valid) begin
               tx_data_d = src_data;
               tx_req_d  = 1'b1;
               state_d   = REQ;
            end
         end
         REQ: begin
            if (ack_s || to_hit) begin
               tx_req_d = 1'b0;
               state_d  = ACK_LOW;
            end
         end
         ACK_LOW: begin
            if (!ack_s) begin
               src_done_d = 1'b1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         tx_req_q   <= 1'b0;
         tx_data_q  <= '0;
         src_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_req_q   <= tx_req_d;
         tx_data_q  <= tx_data_d;
         src_done_q <= src_done_d;
      end
   end

   assign tx_req   = tx_req_q;
   assign tx_data  = tx_data_q;
   assign src_done = src_done_q;
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Self-checking bench for cdc_hs_tx: directed vector table, corner-case
// sequences and a randomized stream checked against a transaction-level model.
module tb_cdc_hs_tx;

   localparam int S  = 2;
   localparam int DW = 16;
   localparam int TO = 8;

   logic          clk;
   logic          rstn;
   logic          src_valid;
   logic          src_ready;
   logic [DW-1:0] src_data;
   logic          src_done;
   logic          busy;
   logic          tx_req;
   logic [DW-1:0] tx_data;
   logic          tx_ack_async;
   logic          timeout_err;

   logic          man_ack;
   logic          rsp_ack;
   logic          auto_rsp;
   int            rsp_d;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [DW-1:0] data;
      int            rsp_dly;
      int            rel_dly;
      logic [DW-1:0] exp_data;
      int            exp_req_lat;
      int            exp_done_lat;
   } vec_t;

   vec_t vecs [5];

   cdc_hs_tx #(
      .DATA_WIDTH     (DW),
      .SYNC_STAGES    (S),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .src_valid    (src_valid),
      .src_ready    (src_ready),
      .src_data     (src_data),
      .src_done     (src_done),
      .busy         (busy),
      .tx_req       (tx_req),
      .tx_data      (tx_data),
      .tx_ack_async (tx_ack_async),
      .timeout_err  (timeout_err)
   );

   assign tx_ack_async = auto_rsp ? rsp_ack : man_ack;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Destination-domain stand-in: 4-phase ack with random response delays.
   initial begin
      rsp_ack = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (!auto_rsp) begin
            rsp_ack = 1'b0;
         end else if (!rsp_ack && tx_req) begin
            rsp_d = $urandom_range(0, 3);
            repeat (rsp_d) @(posedge clk);
            #2;
            rsp_ack = 1'b1;
         end else if (rsp_ack && !tx_req) begin
            rsp_d = $urandom_range(0, 3);
            repeat (rsp_d) @(posedge clk);
            #2;
            rsp_ack = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Latencies are counted from the first clk edge that samples the ack change.
   task automatic do_xfer(input vec_t v);
      int n;
      src_valid = 1'b1;
      src_data  = v.data;
      chk("ready_before_accept", src_ready, 1);
      tick();
      src_valid = 1'b0;
      src_data  = ~v.data;
      chk("req_after_accept", tx_req, 1);
      chk("data_after_accept", tx_data, v.exp_data);
      chk("busy_after_accept", busy, 1);
      chk("ready_low_in_req", src_ready, 0);
      repeat (v.rsp_dly) tick();
      man_ack = 1'b1;
      tick();
      n = 0;
      while (tx_req === 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk("req_fall_latency", n, v.exp_req_lat);
      chk("data_hold_ack_high", tx_data, v.exp_data);
      repeat (v.rel_dly) tick();
      chk("no_done_while_ack_high", src_done, 0);
      man_ack = 1'b0;
      tick();
      n = 0;
      while (src_done !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk("done_latency", n, v.exp_done_lat);
      chk("ready_on_done", src_ready, 1);
      chk("idle_on_done", busy, 0);
      chk("data_held_after_done", tx_data, v.exp_data);
      tick();
      chk("done_single_pulse", src_done, 0);
   endtask

   // Model: words accepted in order must appear on tx_data at each request,
   // stay put while a transfer is in flight, and each closes with one done.
   task automatic run_stream(input int nwords, input bit rnd, input int budget);
      logic [DW-1:0] exp_q[$];
      logic [DW-1:0] w;
      logic [DW-1:0] prev_data;
      logic          prev_req;
      logic          prev_busy;
      logic          take;
      int            acc;
      int            dones;
      int            cyc;
      acc       = 0;
      dones     = 0;
      cyc       = 0;
      prev_req  = tx_req;
      prev_busy = busy;
      prev_data = tx_data;
      w         = rnd ? DW'($urandom) : DW'(1);
      auto_rsp  = 1'b1;
      while ((acc < nwords || busy) && cyc < budget) begin
         if (acc < nwords) begin
            src_valid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            src_data  = w;
         end else begin
            src_valid = 1'b0;
            src_data  = DW'($urandom);
         end
         take = src_valid && src_ready;
         tick();
         cyc++;
         if (take) begin
            exp_q.push_back(w);
            acc++;
            w = rnd ? DW'($urandom) : w + DW'(1);
            chk("stream_req_after_accept", tx_req, 1);
         end
         if (tx_req && !prev_req) begin
            if (exp_q.size() == 0) begin
               chk("stream_unexpected_req", 1, 0);
            end else begin
               chk("stream_word_order", tx_data, exp_q.pop_front());
            end
         end
         if (prev_busy && busy) chk("stream_data_stable", tx_data, prev_data);
         chk("stream_no_timeout", timeout_err, 0);
         if (src_done) dones++;
         prev_req  = tx_req;
         prev_busy = busy;
         prev_data = tx_data;
      end
      src_valid = 1'b0;
      auto_rsp  = 1'b0;
      chk("stream_within_budget", cyc < budget, 1);
      chk("stream_accept_count", acc, nwords);
      chk("stream_done_count", dones, nwords);
      chk("stream_queue_drained", exp_q.size(), 0);
      tick();
   endtask

   initial begin
      int n;
      int bad;
      vec_t v;
      vecs[0] = '{16'hA5C3, 3, 2, 16'hA5C3, S, S};
      vecs[1] = '{16'hFFFF, 0, 0, 16'hFFFF, S, S};
      vecs[2] = '{16'h0001, 5, 1, 16'h0001, S, S};
      vecs[3] = '{16'h8000, 1, 4, 16'h8000, S, S};
      vecs[4] = '{16'h5A3C, 2, 3, 16'h5A3C, S, S};

      rstn      = 1'b0;
      src_valid = 1'b0;
      src_data  = '0;
      man_ack   = 1'b0;
      auto_rsp  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_tx_req", tx_req, 0);
      chk("reset_tx_data", tx_data, 0);
      chk("reset_src_ready", src_ready, 1);
      chk("reset_busy", busy, 0);
      chk("reset_src_done", src_done, 0);
      chk("reset_timeout_err", timeout_err, 0);
      rstn = 1'b1;
      tick();

      for (int i = 0; i < 5; i++) do_xfer(vecs[i]);

      // Ack glitch in IDLE straddling one clk edge.
      #7 man_ack = 1'b1;
      #4 man_ack = 1'b0;
      tick();
      bad = 0;
      for (int i = 0; i < S + 3; i++) begin
         if (busy !== 1'b0 || tx_req !== 1'b0 || src_done !== 1'b0 || src_ready !== 1'b1) bad++;
         tick();
      end
      chk("glitch_ignored_in_idle", bad, 0);
      v = '{16'h3C3C, 2, 1, 16'h3C3C, S, S};
      do_xfer(v);

      run_stream(4, 1'b0, 200);

      // Asynchronous reset while waiting in REQ.
      src_valid = 1'b1;
      src_data  = 16'h1234;
      tick();
      src_valid = 1'b0;
      chk("pre_reset_req", tx_req, 1);
      #3 rstn = 1'b0;
      #1;
      chk("async_reset_tx_req", tx_req, 0);
      chk("async_reset_ready", src_ready, 1);
      chk("async_reset_busy", busy, 0);
      chk("async_reset_tx_data", tx_data, 0);
      tick();
      rstn = 1'b1;
      tick();
      v = '{16'h4321, 1, 1, 16'h4321, S, S};
      do_xfer(v);

      // Ack never returns.
      src_valid = 1'b1;
      src_data  = 16'hBEEF;
      tick();
      src_valid = 1'b0;
`ifdef CDC_HS_TX_TIMEOUT_EN
      n = 0;
      while (timeout_err !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk("timeout_latency", n, TO);
      chk("timeout_req_drop", tx_req, 0);
      tick();
      chk("timeout_single_pulse", timeout_err, 0);
      n = 1;
      while (src_done !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk("timeout_done_follows", n <= S + 1, 1);
      tick();
      chk("timeout_back_idle", src_ready, 1);
`else
      bad = 0;
      for (int i = 0; i < 3 * TO; i++) begin
         tick();
         if (timeout_err !== 1'b0 || tx_req !== 1'b1) bad++;
      end
      chk("no_timeout_waits", bad, 0);
      man_ack = 1'b1;
      n = 0;
      while (tx_req === 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk("late_ack_closes_req", tx_req, 0);
      man_ack = 1'b0;
      n = 0;
      while (src_done !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk("late_ack_done", src_done, 1);
      tick();
`endif

      run_stream(40, 1'b1, 3000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
